// File: rtl/shift_add_mult_16bit.sv
// 16x16 unsigned shift-add multiplier (FSM plus 16-bit ripple-of-CLA adder); EARLY_TERM_EN enables the zero-operand shortcut.
// Latency: done 17 cycles after start is accepted (1 cycle for a zero operand with EARLY_TERM_EN); start is ignored while busy.

module cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = ci;
  assign c[1] = g[0] | (p[0] & ci);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s    = p ^ c;
endmodule

module CLA_16bit_with_RC (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);
  // Four lookahead nibbles, carry rippled between them.
  logic [4:0] c;
  assign c[0] = cin;
  assign cout = c[4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_nib
      cla_4bit u_nib (
        .a  (a[4*gi +: 4]),
        .b  (b[4*gi +: 4]),
        .ci (c[gi]),
        .s  (sum[4*gi +: 4]),
        .co (c[gi+1])
      );
    end
  endgenerate
endmodule

module shift_add_mult_16bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] multiplicand,
  input  logic [15:0] multiplier,
  output logic [31:0] product,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state;
  logic [31:0] p_reg;
  logic [15:0] m_reg;
  logic [4:0]  cnt;
  logic [15:0] add_b;
  logic [15:0] add_s;
  logic        add_c;
  logic [31:0] p_next;
  logic        early;

  assign add_b = p_reg[0] ? m_reg : 16'h0000;

  CLA_16bit_with_RC u_adder (
    .a    (p_reg[31:16]),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_s),
    .cout (add_c)
  );

  // Carry lands in bit 31 so the 32-bit result can never overflow.
  assign p_next = {add_c, add_s, p_reg[15:1]};

`ifdef EARLY_TERM_EN
  assign early = (multiplicand == 16'h0000) || (multiplier == 16'h0000);
`else
  assign early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      p_reg   <= 32'h0;
      m_reg   <= 16'h0;
      cnt     <= 5'd0;
      product <= 32'h0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= multiplicand;
            cnt   <= 5'd0;
            busy  <= 1'b1;
            if (early) begin
              p_reg   <= 32'h0;
              product <= 32'h0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              p_reg <= {16'h0000, multiplier};
              state <= CALC;
            end
          end
        end
        CALC: begin
          p_reg <= p_next;
          cnt   <= cnt + 5'd1;
          if (cnt == 5'd15) begin
            product <= p_next;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shift_add_mult_16bit.sv
// Self-checking bench for shift_add_mult_16bit: directed table, abort/back-to-back sequences, random regression vs M*Q.
module tb_shift_add_mult_16bit;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] multiplicand;
  logic [15:0] multiplier;
  logic [31:0] product;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  shift_add_mult_16bit dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .product      (product),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] m;
    logic [15:0] q;
    logic [31:0] prod;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [15:0] m, input logic [15:0] q);
    logic [31:0] a;
    logic [31:0] b;
    a = {16'h0000, m};
    b = {16'h0000, q};
    return a * b;
  endfunction

  function automatic int exp_lat(input logic [15:0] m, input logic [15:0] q);
`ifdef EARLY_TERM_EN
    if (m == 16'h0000 || q == 16'h0000) return 1;
`endif
    return 17;
  endfunction

  // Presents start with (m,q), switches operands to (m2,q2) after acceptance,
  // and counts cycles until done (bounded). busy_ok reports busy stayed high.
  task automatic run_op(input logic [15:0] m, input logic [15:0] q,
                        input logic [15:0] m2, input logic [15:0] q2,
                        input bit keep_start,
                        output logic [31:0] prod, output int lat, output bit busy_ok);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    step();
    if (!keep_start) start = 1'b0;
    multiplicand = m2;
    multiplier   = q2;
    lat     = 1;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      step();
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    prod = product;
  endtask

  initial begin
    logic [31:0] prod;
    int          lat;
    bit          busy_ok;
    logic [15:0] rm;
    logic [15:0] rq;
    bit          stale;

    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{16'h1234, 16'h0000, 32'h00000000};
    vecs[3] = '{16'h0000, 16'hABCD, 32'h00000000};
    vecs[4] = '{16'h0001, 16'hFFFF, 32'h0000FFFF};
    vecs[5] = '{16'h8000, 16'h8000, 32'h40000000};
    vecs[6] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
    vecs[7] = '{16'h00FF, 16'h0101, 32'h0000FFFF};

    rst = 1'b1;
    start = 1'b1;
    multiplicand = 16'h1111;
    multiplier = 16'h2222;
    step();
    step();
    check("reset_product", product, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_done", {31'h0, done}, 32'h0);
    rst = 1'b0;
    start = 1'b0;
    step();

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].m, vecs[i].q, vecs[i].m, vecs[i].q, 1'b0, prod, lat, busy_ok);
      check($sformatf("vec%0d_product", i), prod, vecs[i].prod);
      check($sformatf("vec%0d_latency", i), lat, exp_lat(vecs[i].m, vecs[i].q));
      check($sformatf("vec%0d_busy_held", i), {31'h0, busy_ok}, 32'h1);
      step();
      check($sformatf("vec%0d_done_width", i), {31'h0, done}, 32'h0);
      check($sformatf("vec%0d_busy_drop", i), {31'h0, busy}, 32'h0);
    end

    // Abort mid-CALC, then restart in the first cycle after reset release.
    multiplicand = 16'h0005;
    multiplier = 16'h0009;
    start = 1'b1;
    step();
    start = 1'b0;
    stale = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) stale = 1'b1;
      step();
    end
    rst = 1'b1;
    step();
    check("abort_busy", {31'h0, busy}, 32'h0);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_product", product, 32'h0);
    rst = 1'b0;
    run_op(16'h0002, 16'h0007, 16'h0002, 16'h0007, 1'b0, prod, lat, busy_ok);
    check("abort_no_early_done", {31'h0, stale}, 32'h0);
    check("after_abort_product", prod, 32'h0000000E);
    check("after_abort_latency", lat, 17);
    step();
    check("after_abort_done_width", {31'h0, done}, 32'h0);

    // start held high; operands change mid-operation.
    run_op(16'h1234, 16'h5678, 16'hBEEF, 16'h0101, 1'b1, prod, lat, busy_ok);
    check("b2b_first_product", prod, ref_mul(16'h1234, 16'h5678));
    check("b2b_first_latency", lat, 17);
    step();
    check("b2b_idle_done", {31'h0, done}, 32'h0);
    check("b2b_idle_busy", {31'h0, busy}, 32'h0);
    step();
    check("b2b_reaccept_busy", {31'h0, busy}, 32'h1);
    lat = 1;
    while (!done && lat < 40) begin
      step();
      lat++;
    end
    start = 1'b0;
    check("b2b_second_product", product, ref_mul(16'hBEEF, 16'h0101));
    check("b2b_second_latency", lat, 17);
    step();
    check("b2b_second_done_width", {31'h0, done}, 32'h0);

    for (int n = 0; n < 2500; n++) begin
      case ($urandom_range(0, 15))
        0: rm = 16'h0000;
        1: rm = 16'hFFFF;
        default: rm = 16'($urandom);
      endcase
      case ($urandom_range(0, 15))
        0: rq = 16'h0000;
        1: rq = 16'hFFFF;
        default: rq = 16'($urandom);
      endcase
      run_op(rm, rq, 16'($urandom), 16'($urandom), 1'b0, prod, lat, busy_ok);
      check("rand_product", prod, ref_mul(rm, rq));
      check("rand_latency", lat, exp_lat(rm, rq));
      step();
      check("rand_done_width", {31'h0, done}, 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
